// File: rtl/serial_tx.sv
// 8N1 UART transmitter: one frame per accepted txe strobe, LSB first,
// BAUD_DIV system clocks per bit, tx and busy both driven from flops.
//
// state | meaning
// ------+------------------------------------------------------------
// 0     | IDLE   line high, waiting for txe
// 1     | START  start bit (low)
// 2..9  | BIT0..BIT7 data bits, LSB first
// 10    | STOP   stop bit (high)
// 11..15| illegal, return to IDLE on the next edge
module serial_tx #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       txe,
    output logic       tx,
    output logic       busy
);

    localparam logic [3:0]  ST_IDLE  = 4'd0;
    localparam logic [3:0]  ST_START = 4'd1;
    localparam logic [3:0]  ST_BIT0  = 4'd2;
    localparam logic [3:0]  ST_BIT7  = 4'd9;
    localparam logic [3:0]  ST_STOP  = 4'd10;
    localparam logic [31:0] BAUD_TC  = 32'(BAUD_DIV - 1);

    logic [3:0]  state_q, state_d;
    logic [31:0] baudcounter_q, baudcounter_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        bit_done;

    // Kept under these names so benches can probe them hierarchically.
    logic [3:0]  state;
    logic [31:0] baudcounter;

    assign state       = state_q;
    assign baudcounter = baudcounter_q;
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign bit_done    = (baudcounter_q == BAUD_TC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            baudcounter_q <= 32'd0;
            shift_q       <= 8'd0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            baudcounter_q <= baudcounter_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        baudcounter_d = baudcounter_q;
        shift_d       = shift_q;
        if (state_q == ST_IDLE) begin
            if (txe) begin
                state_d       = ST_START;
                baudcounter_d = 32'd0;
                shift_d       = data;
            end
        end else if (state_q > ST_STOP) begin
            state_d       = ST_IDLE;
            baudcounter_d = 32'd0;
        end else if (bit_done) begin
            baudcounter_d = 32'd0;
            if (state_q == ST_STOP) begin
                state_d = ST_IDLE;
            end else begin
                state_d = state_q + 4'd1;
                shift_d = shift_q >> 1;
            end
        end else begin
            baudcounter_d = baudcounter_q + 32'd1;
        end
    end

    // Outputs are registered from the next state; on entry to a data bit the
    // LSB is taken before this edge's shift, so BIT0 carries data[0].
    always_comb begin
        tx_d   = tx_q;
        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_START) begin
            tx_d = 1'b0;
        end else if (state_d >= ST_BIT0 && state_d <= ST_BIT7) begin
            if (state_d != state_q) begin
                tx_d = shift_q[0];
            end
        end else begin
            tx_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed frame table, corner-case
// sequences and randomized traffic against a frame-level reference model.
module tb_serial_tx;

    localparam int BD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       txe;
    logic       tx;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    serial_tx #(.BAUD_DIV(BD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .data (data),
        .txe  (txe),
        .tx   (tx),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a frame is the 10-entry list {start, d0..d7, stop};
    // m_n counts edges since acceptance and selects slot m_n / BD.
    bit       m_active = 1'b0;
    int       m_n      = 0;
    bit [9:0] m_frame  = 10'h3FF;
    bit       mdl_en   = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_n++;
            if (m_n == 10 * BD) m_active = 1'b0;
        end else if (txe) begin
            m_active = 1'b1;
            m_n      = 0;
            m_frame[0] = 1'b0;
            for (int k = 0; k < 8; k++) m_frame[k + 1] = data[k];
            m_frame[9] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mdl_en) begin
            chk("model_tx", 32'(tx), m_active ? 32'(m_frame[m_n / BD]) : 32'd1);
            chk("model_busy", 32'(busy), 32'(m_active));
        end
    end

    typedef struct {
        logic [7:0] d;
        logic [9:0] exp;
        int         restrobe;
    } vec_t;

    vec_t vecs[5];

    task automatic run_frame(input logic [7:0] d, input logic [9:0] exp, input int restrobe,
                             input string nm);
        int busy_cycles;
        @(negedge clk);
        data = d;
        txe  = 1'b1;
        @(negedge clk);
        txe  = 1'b0;
        data = 8'($urandom);
        busy_cycles = 0;
        for (int i = 0; i < 10 * BD; i++) begin
            if (i > 0) @(negedge clk);
            if (i == restrobe) begin
                txe  = 1'b1;
                data = ~d;
            end else begin
                txe = 1'b0;
            end
            chk($sformatf("%s_tx%0d", nm, i), 32'(tx), 32'(exp[i / BD]));
            if (busy === 1'b1) busy_cycles++;
        end
        chk($sformatf("%s_busy_len", nm), 32'(busy_cycles), 32'(10 * BD));
        @(negedge clk);
        txe = 1'b0;
        chk($sformatf("%s_end_tx", nm), 32'(tx), 32'd1);
        chk($sformatf("%s_end_busy", nm), 32'(busy), 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk($sformatf("%s_no_second", nm), 32'(busy), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{d: 8'hFF, exp: 10'b1111111110, restrobe: -1};
        vecs[1] = '{d: 8'h55, exp: 10'b1010101010, restrobe: -1};
        vecs[2] = '{d: 8'hA5, exp: 10'b1101001010, restrobe: -1};
        vecs[3] = '{d: 8'h3C, exp: 10'b1001111000, restrobe: 10};
        vecs[4] = '{d: 8'h81, exp: 10'b1100000010, restrobe: -1};

        rst_n = 1'b0;
        txe   = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_state", 32'(dut.state), 32'd0);
            chk("rst_cnt", dut.baudcounter, 32'd0);
        end
        mdl_en = 1'b1;

        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].d, vecs[v].exp, vecs[v].restrobe, $sformatf("vec%0d", v));

        // Reset in the middle of BIT3, then a clean frame.
        @(negedge clk);
        data = 8'h3C;
        txe  = 1'b1;
        @(negedge clk);
        txe  = 1'b0;
        repeat (17) @(negedge clk);
        chk("mid_state_bit3", 32'(dut.state), 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_state", 32'(dut.state), 32'd0);
        chk("mid_rst_cnt", dut.baudcounter, 32'd0);
        rst_n = 1'b1;
        run_frame(8'hC3, 10'b1110000110, -1, "after_rst");

        // txe held high with 0x00: 40-cycle frames separated by one idle cycle.
        @(negedge clk);
        data = 8'h00;
        txe  = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 3 * (10 * BD + 1); j++) begin
            int k;
            if (j > 0) @(negedge clk);
            if (j == 3 * (10 * BD + 1) - 1) txe = 1'b0;
            k = j % (10 * BD + 1);
            chk($sformatf("cont_tx%0d", j), 32'(tx), (k < BD || k >= 10 * BD) ?
                ((k < BD) ? 32'd0 : 32'd1) : ((k >= 9 * BD) ? 32'd1 : 32'd0));
            chk($sformatf("cont_busy%0d", j), 32'(busy), (k < 10 * BD) ? 32'd1 : 32'd0);
        end
        repeat (3) begin
            @(negedge clk);
            chk("cont_stopped", 32'(busy), 32'd0);
        end

        // Random traffic with stray strobes and occasional resets.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            txe   = ($urandom_range(0, 7) == 0);
            data  = 8'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        txe   = 1'b0;
        rst_n = 1'b1;
        repeat (10 * BD + 5) @(negedge clk);
        chk("final_idle_busy", 32'(busy), 32'd0);
        chk("final_idle_tx", 32'(tx), 32'd1);

        mdl_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Byte-wide UART transmitter, 8N1 format, LSB first, fixed baud rate derived from the system clock by an integer divisor. It sits between a byte producer and the serial line pin. Each one-cycle `txe` strobe in idle launches one 10-bit frame on `tx`. Strobes that arrive while a frame is in flight are ignored.

## Interface
- `BAUD_DIV`, default 434: clock cycles per bit (50 MHz / 115200); legal range 2 .. 2^32-1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `data`  in  8  byte to send; sampled only on the accepting edge.
- `txe`  in  1  transmit enable strobe; level-sampled while idle.
- `tx`  out  1  serial line, idle high; registered output.
- `busy`  out  1  high while a frame is in progress; registered.

## Operation
- Internal 4-bit `state` and 32-bit `baudcounter`; both names are kept so benches can probe them hierarchically.
- States:
  - IDLE=0: `tx`=1, `busy`=0.
  - START=1: `tx`=0.
  - BIT0..BIT7=2..9: `tx`=shift-register LSB.
  - STOP=10: `tx`=1.
  - Codes 11..15 are illegal and return to IDLE on the next edge.
- IDLE:
  - If `txe`=1 on an edge, latch `data` into the shift register and go to START.
  - On the same edge: `baudcounter`<=0, `busy`<=1, `tx`<=0.
- Every non-IDLE state lasts exactly `BAUD_DIV` cycles:
  - `baudcounter` increments each cycle.
  - On reaching `BAUD_DIV`-1 it wraps to 0 and the state advances.
  - On each advance from START or BITn, the shift register shifts right one place.
- STOP complete -> IDLE with `busy`<=0. `tx` stays 1.
- `txe` is ignored in every state except IDLE. There is no queueing.
- `data` changes outside the accepting edge have no effect on the frame in flight.
- `txe` held high: a new frame starts on the first IDLE cycle, giving back-to-back frames separated by one idle cycle.
- Reset (`rst_n`=0 on an edge), including mid-frame:
  - Frame is aborted.
  - `state`=IDLE, `baudcounter`=0, shift register=0, `tx`=1, `busy`=0.
  - Reset overrides `txe`.

## Timing
- Latency: edge E accepts `txe`. `tx` falls immediately after E; the start bit occupies cycles E+1 .. E+`BAUD_DIV`.
- Bit k (k=0..7) occupies cycles E+1+(k+1)·`BAUD_DIV` .. E+(k+2)·`BAUD_DIV`.
- The stop bit occupies cycles up to E+10·`BAUD_DIV`. `busy` falls at edge E+10·`BAUD_DIV`.
- Minimum accept-to-accept spacing: 10·`BAUD_DIV`+1 cycles.
- `busy` is asserted on exactly the cycles the frame is driven: 10·`BAUD_DIV` cycles.
- No glitches on `tx`: it is a flop output and changes only at bit boundaries.

## Test plan
Use `BAUD_DIV`=4, 20 ns clock.
- Reset then idle: hold `rst_n`=0 for 2 cycles, then release with `txe`=0 -> `tx`=1, `busy`=0, `state`=0, `baudcounter`=0 indefinitely.
- Send `data`=8'hFF with a one-cycle `txe`:
  - `tx`=0 for 4 cycles, then 1 for 36 cycles.
  - `busy` is high for exactly 40 cycles.
- Send `data`=8'h55: `tx` sequence per 4-cycle bit is 0,1,0,1,0,1,0,1,0,1. Repeat with 8'hA5 and check LSB-first ordering.
- Ignored strobe: pulse `txe` again 10 cycles into a frame with different `data` -> frame unchanged, no second frame, `busy` falls at cycle 40.
- Mid-frame reset: assert `rst_n`=0 during BIT3 -> next edge gives `tx`=1, `busy`=0, `state`=0. A subsequent `txe` sends a clean full frame.
- Continuous `txe`=1 with 8'h00:
  - Frames repeat every 41 cycles with one `tx`=1 idle cycle between stop and start.
  - Each frame is 1 start, 8 data bits of 0, 1 stop.
